// File: rtl/signext_arb_pkg.sv
// Shared types and constants for the immediate-extension arbiter.
package signext_arb_pkg;

    typedef enum logic {
        EXT_SIGN = 1'b0,
        EXT_ZERO = 1'b1
    } ext_mode_t;

    localparam int unsigned DEF_IN_W  = 16;
    localparam int unsigned DEF_OUT_W = 32;

    localparam logic REQ_DEC = 1'b0;
    localparam logic REQ_LD  = 1'b1;

    // One-hot grant; on contention the requester not granted last time wins.
    function automatic logic [1:0] pick_grant(input logic [1:0] valid, input logic last_grant);
        logic [1:0] grant;
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/signext_arb_ext_unit.sv
// Combinational sign/zero extender shared by both requesters.
module ext_unit
    import signext_arb_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W
) (
    input  logic [IN_W-1:0]  data,
    input  logic             mode,
    output logic [OUT_W-1:0] result
);

    logic w_fill;

    always_comb begin
        w_fill = (mode == EXT_ZERO) ? 1'b0 : data[IN_W-1];
        result = {{(OUT_W-IN_W){w_fill}}, data};
    end

endmodule

// File: rtl/signext_arb.sv
// Round-robin arbiter that time-shares one extender between decode and load-align.
module signext_arb
    import signext_arb_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [IN_W-1:0]  req0_data,
    input  logic [IN_W-1:0]  req1_data,
    input  logic [1:0]       req_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_id
);

    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_id;
    logic             r_last_grant;

    logic             w_can_accept;
    logic [1:0]       w_grant;
    logic             w_xfer;
    logic             w_sel;
    logic [IN_W-1:0]  w_data;
    logic             w_mode;
    logic [OUT_W-1:0] w_result;

    always_comb begin
        w_can_accept = !r_out_valid || out_ready;
        w_grant      = pick_grant(req_valid, r_last_grant);
        // Nothing is accepted while reset is asserted.
        req_ready    = rst ? 2'b00 : (w_grant & {2{w_can_accept}});
        w_xfer       = |req_ready;
        w_sel        = w_grant[1] ? REQ_LD : REQ_DEC;
        w_data       = (w_sel == REQ_LD) ? req1_data : req0_data;
        w_mode       = req_mode[w_sel];
    end

    ext_unit #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_ext (
        .data   (w_data),
        .mode   (w_mode),
        .result (w_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_id     <= REQ_DEC;
            r_last_grant <= REQ_LD;
        end else if (w_xfer) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= w_result;
            r_out_id     <= w_sel;
            r_last_grant <= w_sel;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

endmodule

// File: tb/tb_signext_arb.sv
// Directed vector table plus randomized run against a behavioural model of signext_arb.
module tb_signext_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req0_data;
    logic [15:0] req1_data;
    logic [1:0]  req_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_id;

    int n_total = 0;
    int n_bad   = 0;

    // Model state: the result slot and who was granted last.
    bit          m_valid;
    logic [31:0] m_data;
    int          m_id;
    int          m_last;

    always #5 clk = ~clk;

    signext_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_data (req0_data),
        .req1_data (req1_data),
        .req_mode  (req_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  valid;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  mode;
        logic        oready;
        logic        ev;
        logic [31:0] ed;
        logic        eid;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext(input logic [15:0] d, input bit zero);
        int unsigned v;
        v = d;
        if (!zero && v >= 32768) v = v + 32'hFFFF0000;
        return v;
    endfunction

    function automatic void model_reset();
        m_valid = 0;
        m_data  = 0;
        m_id    = 0;
        m_last  = 1;
    endfunction

    // Drive one cycle's inputs, check combinational ready and current outputs, then clock.
    task automatic cycle(input logic r, input logic [1:0] v, input logic [15:0] d0,
                         input logic [15:0] d1, input logic [1:0] md, input logic ordy);
        int          g;
        logic [1:0]  exp_ready;
        rst = r; req_valid = v; req0_data = d0; req1_data = d1; req_mode = md; out_ready = ordy;
        #1;
        g = -1;
        if (!r && (!m_valid || ordy)) begin
            if (v == 2'b11) g = 1 - m_last;
            else if (v == 2'b01) g = 0;
            else if (v == 2'b10) g = 1;
        end
        exp_ready = (g < 0) ? 2'b00 : 2'(1 << g);
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", out_data, m_data);
        check("out_id", 32'(out_id), 32'(m_id));
        if (r) begin
            model_reset();
        end else if (g >= 0) begin
            m_data  = ext((g == 1) ? d1 : d0, md[g]);
            m_id    = g;
            m_valid = 1;
            m_last  = g;
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1; req_valid = 2'b11; req0_data = '0; req1_data = '0;
        req_mode = 2'b00; out_ready = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        // Reset held with both requesters valid, then first contention, extensions,
        // alternating contention, backpressure, and reset while a result is pending.
        vecs.push_back('{1, 2'b11, 16'h8001, 16'h8001, 2'b10, 1, 0, 32'h0, 0});
        vecs.push_back('{1, 2'b11, 16'h8001, 16'h8001, 2'b10, 1, 0, 32'h0, 0});
        vecs.push_back('{0, 2'b11, 16'h8001, 16'h8001, 2'b10, 1, 1, 32'hFFFF8001, 0});
        vecs.push_back('{0, 2'b10, 16'h8001, 16'h8001, 2'b10, 1, 1, 32'h00008001, 1});
        vecs.push_back('{0, 2'b01, 16'h7FFF, 16'h0000, 2'b00, 1, 1, 32'h00007FFF, 0});
        vecs.push_back('{0, 2'b00, 16'h0000, 16'h0000, 2'b00, 1, 0, 32'h00007FFF, 0});
        vecs.push_back('{0, 2'b10, 16'h0000, 16'h0042, 2'b00, 1, 1, 32'h00000042, 1});
        for (int i = 0; i < 6; i++)
            vecs.push_back('{0, 2'b11, 16'hA5A5, 16'h5A5A, 2'b00, 1, 1,
                             (i % 2 == 0) ? 32'hFFFFA5A5 : 32'h00005A5A, 1'(i % 2)});
        for (int i = 0; i < 3; i++)
            vecs.push_back('{0, 2'b01, 16'h1234, 16'h0000, 2'b00, 0, 1, 32'h00005A5A, 1});
        vecs.push_back('{0, 2'b01, 16'h1234, 16'h0000, 2'b00, 1, 1, 32'h00001234, 0});
        vecs.push_back('{0, 2'b10, 16'h0000, 16'hBEEF, 2'b00, 0, 1, 32'h00001234, 0});
        vecs.push_back('{1, 2'b10, 16'h0000, 16'hBEEF, 2'b00, 0, 0, 32'h0, 0});
        vecs.push_back('{0, 2'b00, 16'h0000, 16'hBEEF, 2'b00, 1, 0, 32'h0, 0});

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].mode,
                  vecs[i].oready);
            check($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d.data", i), out_data, vecs[i].ed);
            check($sformatf("vec%0d.id", i), 32'(out_id), 32'(vecs[i].eid));
        end

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) == 0), 2'($urandom), 16'($urandom), 16'($urandom),
                  2'($urandom), ($urandom_range(0, 3) != 0));
        end
        cycle(1'b0, 2'b00, 16'h0, 16'h0, 2'b00, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
